ext_int_ctrl: RTL and testbench
===============================

# ext_int_ctrl

Multi-channel external interrupt controller for board integration. It takes `NUM_CH` raw button/pin inputs and, per channel, synchronises, debounces and detects events in edge or level mode. Events latch into a pending register, and a fixed-priority arbiter presents one interrupt at a time to the CPU core. Each interrupt carries a channel ID and uses an acknowledge handshake, with a watchdog auto-clear. It replaces the single-button interrupt generator between the board I/O pins and the pipeline's interrupt/exception unit.

## Interface
- `NUM_CH`, 4: number of input channels, 1..32.
- `DEBOUNCE_LIMIT`, 1000000: consecutive stable cycles required to accept a new input level (~10 ms at 100 MHz), ≥2.
- `TIMEOUT`, 255: cycles `external_int` may stay high without ack before auto-clear; 0 disables auto-clear.
- `IDW`, derived: `$clog2(NUM_CH)`, minimum 1.

- `clk`  in  1: system clock; single clock domain.
- `reset_n`  in  1: reset, asynchronous assert, active-low.
- `btn_i`  in  NUM_CH: raw asynchronous inputs, active-high.
- `edge_sel`  in  NUM_CH: per channel, 1 = rising-edge mode, 0 = level-high mode.
- `int_mask`  in  NUM_CH: 1 = channel masked (blocked from arbitration; pending still latches).
- `ext_int_ack`  in  1: acknowledge from the core; honoured only while `external_int`=1.
- `external_int`  out  1: interrupt request to the core (registered).
- `int_id`  out  IDW: channel in service; valid while `external_int`=1, held after.
- `int_pending`  out  NUM_CH: pending register, visible for status reads.
- `timeout_o`  out  1: one-cycle pulse when a request is auto-cleared.

## Operation
- **Reset** (`reset_n`=0, any time, including mid-request): all outputs are 0, including `int_id`. Sync flops, debounced levels, `deb_prev`, debounce counters, pending bits and the timeout counter all clear.
- **Synchroniser**: each channel passes through a 2-flop chain (`sync1` → `sync2`).
- **Debounce** (per channel):
  - If `sync2` == `deb`, the counter returns to 0.
  - Otherwise the counter increments. When it equals `DEBOUNCE_LIMIT-1`, `deb` takes `sync2` and the counter returns to 0.
  - Counter width is `$clog2(DEBOUNCE_LIMIT)`. It never wraps.
- **Event detect**, using registered `deb_prev`:
  - Edge mode: set request = `deb & ~deb_prev`.
  - Level mode: set request = `deb`.
- **Pending**:
  - A set request sets the channel's pending bit.
  - Granting the channel clears its pending bit.
  - If a set and a clear hit the same bit on the same edge, set wins.
  - Repeat events while a bit is already pending merge into it; no count is kept.
- **Arbiter**, two states:
  - IDLE (`external_int`=0): if `int_pending & ~int_mask` ≠ 0, grant the lowest-index channel. Set `external_int`=1, load `int_id`, clear that pending bit, zero the timeout counter, go to ACTIVE.
  - ACTIVE, `ext_int_ack`=1: `external_int` goes to 0, go to IDLE.
  - ACTIVE, no ack, `TIMEOUT`≠0: the counter increments. On the edge where the counter equals `TIMEOUT-1`, `external_int` goes to 0, `timeout_o` goes to 1 for one cycle, go to IDLE.
  - If ack and timeout coincide, ack wins and no `timeout_o` pulse is produced.
- `ext_int_ack` in IDLE is ignored.
- Changes to `int_mask` or `edge_sel` do not affect a request already in service.
- A masked pending bit is held until the channel is unmasked, then it is granted.
- Level mode with the input held high re-pends the channel on the cycle after grant, so it re-requests after every ack.

## Timing
- Input high sampled at edge k: `sync2` at k+1, `deb` at k+1+L (L = `DEBOUNCE_LIMIT`), pending at k+2+L, `external_int` at k+3+L.
- Glitches shorter than L cycles after `sync2` never change `deb`.
- Ack sampled at edge n: `external_int`=0 after edge n.
- Every drop of `external_int` leaves it low for at least 1 cycle before the next grant.
- Without ack, `external_int` stays high for exactly `TIMEOUT` cycles.
- `timeout_o` is high in the same cycle `external_int` first reads 0.

## Test plan
Common parameters: `NUM_CH`=4, `DEBOUNCE_LIMIT`=4, `TIMEOUT`=8.

- **Reset**: hold `reset_n`=0 with `btn_i`=4'hF → all outputs 0. Release → no request for ≥6 cycles if inputs are 0.
- **Glitch reject and edge mode**:
  - Ch0 high for 3 cycles → no pending bit, no `external_int`.
  - Ch2 (`edge_sel`=1) held high → `external_int`=1 with `int_id`=2 at 7 cycles. Ack 2 cycles later → low next cycle.
  - Ch2 kept held → no re-request.
- **Priority**: ch1 and ch3 rise in the same cycle → `int_id`=1 first. Ack → ≥1 low cycle, then `int_id`=3. Ack → IDLE, pending=0.
- **Timeout**: ch0 event with no ack → `external_int` high exactly 8 cycles, `timeout_o` single pulse, `int_pending[0]`=0. Ack on the 8th cycle instead → no pulse.
- **Mask and level mode**:
  - Ch1 masked with an event → `int_pending`=4'b0010, no request. Unmask → grant `int_id`=1.
  - Ch0 in level mode held high → re-requests after each ack.
- **Reset mid-request**: assert `reset_n`=0 while `external_int`=1 and pending=4'b1010 → all cleared asynchronously, before the next clock edge.

Source files
------------

// File: rtl/ext_int_ctrl.sv
// rtl/ext_int_ctrl.sv - multi-channel debounced external interrupt controller with ack and watchdog
module ext_int_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 1000000,
    parameter int TIMEOUT        = 255,
    localparam int IDW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_i,
    input  logic [NUM_CH-1:0] edge_sel,
    input  logic [NUM_CH-1:0] int_mask,
    input  logic              ext_int_ack,
    output logic              external_int,
    output logic [IDW-1:0]    int_id,
    output logic [NUM_CH-1:0] int_pending,
    output logic              timeout_o
);

    localparam int DW = $clog2(DEBOUNCE_LIMIT);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t            state, state_nx;
    logic [NUM_CH-1:0] sync1, sync2, deb, deb_prev;
    logic [DW-1:0]     deb_cnt [NUM_CH];
    logic [NUM_CH-1:0] set_req, avail, grant_clr;
    logic [IDW-1:0]    id_nx;
    logic [TW-1:0]     tcnt, tcnt_nx;
    logic              to_nx;

    // Two-flop synchroniser followed by a per-channel stability counter; the
    // accepted level only moves after DEBOUNCE_LIMIT consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < NUM_CH; i++) deb_cnt[i] <= '0;
        end else begin
            sync1    <= btn_i;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge channels fire once per debounced rise; level channels fire every cycle they are high.
    assign set_req = (edge_sel & deb & ~deb_prev) | (~edge_sel & deb);
    assign avail   = int_pending & ~int_mask;

    // Pending register: a new event on the grant edge wins over the grant's clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) int_pending <= '0;
        else          int_pending <= (int_pending & ~grant_clr) | set_req;
    end

    // Arbiter next state: lowest unmasked pending channel wins; ack beats the watchdog.
    always_comb begin
        state_nx  = state;
        id_nx     = int_id;
        tcnt_nx   = tcnt;
        to_nx     = 1'b0;
        grant_clr = '0;
        case (state)
            S_IDLE: begin
                if (|avail) begin
                    grant_clr = avail & (~avail + 1'b1);
                    for (int i = NUM_CH - 1; i >= 0; i--) begin
                        if (avail[i]) id_nx = IDW'(i);
                    end
                    tcnt_nx  = '0;
                    state_nx = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (ext_int_ack) begin
                    state_nx = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    if (tcnt == TO_MAX) begin
                        state_nx = S_IDLE;
                        to_nx    = 1'b1;
                    end else begin
                        tcnt_nx = tcnt + 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Arbiter registers; external_int is the ACTIVE state flop itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            int_id    <= '0;
            tcnt      <= '0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nx;
            int_id    <= id_nx;
            tcnt      <= tcnt_nx;
            timeout_o <= to_nx;
        end
    end

    assign external_int = (state == S_ACTIVE);

endmodule

// File: tb/tb_ext_int_ctrl.sv
// tb/tb_ext_int_ctrl.sv - self-checking bench for ext_int_ctrl against a behavioural model
module tb_ext_int_ctrl;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] btn_i, edge_sel, int_mask;
    logic         ext_int_ack;
    logic         external_int;
    logic [1:0]   int_id;
    logic [N-1:0] int_pending;
    logic         timeout_o;

    int checks   = 0;
    int failures = 0;
    int n, hi;

    // model state
    logic [N-1:0] bh[$];
    logic [N-1:0] win[$];
    logic [N-1:0] m_deb, m_prev, m_pend;
    bit           m_busy, m_to;
    int           m_age, m_id;

    ext_int_ctrl #(.NUM_CH(N), .DEBOUNCE_LIMIT(L), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .btn_i(btn_i), .edge_sel(edge_sel),
        .int_mask(int_mask), .ext_int_ack(ext_int_ack), .external_int(external_int),
        .int_id(int_id), .int_pending(int_pending), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        bh.delete();
        win.delete();
        bh.push_back('0);
        bh.push_back('0);
        m_deb = '0; m_prev = '0; m_pend = '0;
        m_busy = 0; m_to = 0; m_age = 0; m_id = 0;
    endtask

    // One clock edge of the reference: sync2 is the input seen two edges ago, the
    // accepted level flips once the last L sync2 samples all disagree with it.
    task automatic model_step();
        logic [N-1:0] s2, setv, clr, avail;
        bit           all_diff;
        s2 = bh[0];
        bh.push_back(btn_i);
        void'(bh.pop_front());
        for (int c = 0; c < N; c++)
            setv[c] = edge_sel[c] ? (m_deb[c] & ~m_prev[c]) : m_deb[c];
        m_prev = m_deb;
        win.push_back(s2);
        if (win.size() > L) void'(win.pop_front());
        if (win.size() == L) begin
            for (int c = 0; c < N; c++) begin
                all_diff = 1;
                foreach (win[j]) if (win[j][c] == m_deb[c]) all_diff = 0;
                if (all_diff) m_deb[c] = ~m_deb[c];
            end
        end
        clr  = '0;
        m_to = 0;
        if (!m_busy) begin
            avail = m_pend & ~int_mask;
            if (avail != 0) begin
                for (int c = N - 1; c >= 0; c--) if (avail[c]) m_id = c;
                clr[m_id] = 1'b1;
                m_busy    = 1;
                m_age     = 1;
            end
        end else if (ext_int_ack) begin
            m_busy = 0;
        end else if (m_age == TO) begin
            m_busy = 0;
            m_to   = 1;
        end else begin
            m_age++;
        end
        m_pend = (m_pend & ~clr) | setv;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_ext", external_int, m_busy);
        chk("m_id", int_id, m_id);
        chk("m_pend", int_pending, m_pend);
        chk("m_to", timeout_o, m_to);
    endtask

    task automatic wait_int(output int cnt);
        cnt = 0;
        while (!external_int && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk("wait_int", external_int, 1);
    endtask

    task automatic settle();
        btn_i = '0;
        ext_int_ack = 1'b1;
        repeat (24) cyc();
        ext_int_ack = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic ack_once();
        ext_int_ack = 1'b1;
        cyc();
        ext_int_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; btn_i = 4'hF; edge_sel = '0; int_mask = '0; ext_int_ack = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_ext", external_int, 0);
            chk("rst_id", int_id, 0);
            chk("rst_pend", int_pending, 0);
            chk("rst_to", timeout_o, 0);
        end
        btn_i = '0;
        reset_n = 1'b1;
        repeat (8) begin
            cyc();
            chk("post_rst_quiet", external_int, 0);
        end

        // glitch shorter than the debounce window
        btn_i = 4'b0001;
        repeat (3) cyc();
        btn_i = '0;
        repeat (10) begin
            cyc();
            chk("glitch_pend", int_pending, 0);
            chk("glitch_ext", external_int, 0);
        end

        // edge mode on ch2
        edge_sel = 4'b0100;
        btn_i = 4'b0100;
        cyc();
        wait_int(n);
        chk("edge_latency", n, 7);
        chk("edge_id", int_id, 2);
        cyc();
        cyc();
        ack_once();
        chk("edge_ack_low", external_int, 0);
        repeat (12) begin
            cyc();
            chk("edge_no_rereq", external_int, 0);
        end
        settle();

        // priority: ch1 and ch3 together
        edge_sel = 4'b1010;
        btn_i = 4'b1010;
        wait_int(n);
        chk("prio_first", int_id, 1);
        chk("prio_pend", int_pending, 4'b1000);
        ack_once();
        chk("prio_gap", external_int, 0);
        cyc();
        chk("prio_second_ext", external_int, 1);
        chk("prio_second", int_id, 3);
        ack_once();
        chk("prio_idle", external_int, 0);
        chk("prio_empty", int_pending, 0);
        settle();

        // watchdog auto-clear
        edge_sel = 4'b0001;
        btn_i = 4'b0001;
        wait_int(n);
        hi = 1;
        while (hi < 20) begin
            cyc();
            if (!external_int) break;
            hi++;
        end
        chk("to_high_cycles", hi, TO);
        chk("to_pulse", timeout_o, 1);
        chk("to_pend0", int_pending[0], 0);
        cyc();
        chk("to_single", timeout_o, 0);
        btn_i = '0;
        repeat (10) cyc();
        btn_i = 4'b0001;
        wait_int(n);
        repeat (7) cyc();
        chk("to_ack8_still_high", external_int, 1);
        ack_once();
        chk("to_ack8_low", external_int, 0);
        chk("to_ack8_nopulse", timeout_o, 0);
        cyc();
        chk("to_ack8_nopulse2", timeout_o, 0);
        settle();

        // masked channel holds pending until unmasked
        int_mask = 4'b0010;
        edge_sel = 4'b0010;
        btn_i = 4'b0010;
        repeat (12) cyc();
        chk("mask_pend", int_pending, 4'b0010);
        chk("mask_noreq", external_int, 0);
        int_mask = '0;
        cyc();
        chk("unmask_ext", external_int, 1);
        chk("unmask_id", int_id, 1);
        ack_once();
        settle();

        // level mode re-requests after each ack
        edge_sel = '0;
        btn_i = 4'b0001;
        wait_int(n);
        chk("level_id", int_id, 0);
        for (int r = 0; r < 3; r++) begin
            ack_once();
            chk("level_gap", external_int, 0);
            cyc();
            chk("level_rereq", external_int, 1);
            chk("level_rereq_id", int_id, 0);
        end
        settle();

        // asynchronous reset while a request is in service
        edge_sel = 4'b1111;
        int_mask = 4'b1010;
        btn_i = 4'b1011;
        wait_int(n);
        cyc();
        chk("mid_ext", external_int, 1);
        chk("mid_pend", int_pending, 4'b1010);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_ext", external_int, 0);
        chk("async_id", int_id, 0);
        chk("async_pend", int_pending, 0);
        chk("async_to", timeout_o, 0);
        model_reset();
        btn_i = '0;
        int_mask = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) cyc();

        // randomized traffic against the model
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(9) == 0) btn_i[c] = ~btn_i[c];
            if ($urandom_range(63) == 0) edge_sel = 4'($urandom);
            if ($urandom_range(63) == 0) int_mask = 4'($urandom);
            ext_int_ack = ($urandom_range(5) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
